// File: rtl/mu0_pkg.sv
// Shared constants for the MU0 control unit: opcodes, ALU functions, FSM
// state encoding, datapath select encodings and the packed control vector.
package mu0_pkg;

  localparam logic [3:0] OP_LDA = 4'd0;
  localparam logic [3:0] OP_STA = 4'd1;
  localparam logic [3:0] OP_ADD = 4'd2;
  localparam logic [3:0] OP_SUB = 4'd3;
  localparam logic [3:0] OP_JMP = 4'd4;
  localparam logic [3:0] OP_JGE = 4'd5;
  localparam logic [3:0] OP_JNE = 4'd6;
  localparam logic [3:0] OP_STP = 4'd7;

  localparam logic [1:0] ALU_Y   = 2'b00;
  localparam logic [1:0] ALU_ADD = 2'b01;
  localparam logic [1:0] ALU_INC = 2'b10;
  localparam logic [1:0] ALU_SUB = 2'b11;

  localparam logic [1:0] S_FETCH = 2'd0;
  localparam logic [1:0] S_EXEC  = 2'd1;
  localparam logic [1:0] S_HALT  = 2'd2;

  localparam logic X_ACC = 1'b0;
  localparam logic X_PC  = 1'b1;
  localparam logic Y_MEM = 1'b0;
  localparam logic Y_IMM = 1'b1;
  localparam logic A_PC  = 1'b0;
  localparam logic A_IR  = 1'b1;

  typedef struct packed {
    logic       pc_en;
    logic       ir_en;
    logic       acc_en;
    logic       x_sel;
    logic       y_sel;
    logic       addr_sel;
    logic [1:0] alu_fs;
    logic       rd;
    logic       wr;
    logic       halted;
  } ctrl_t;

endpackage

// File: rtl/mu0_decode.sv
// Combinational decode of {state, opcode, N, Z} into the MU0 control vector,
// plus a halt request used by the state machine in mu0_control.
module mu0_decode
  import mu0_pkg::*;
#(
  parameter int ILLEGAL_HALTS = 0
) (
  input  logic [1:0] state,
  input  logic [3:0] f,
  input  logic       n,
  input  logic       z,
  output ctrl_t      ctrl,
  output logic       halt_req
);

  always_comb begin
    ctrl     = '0;
    halt_req = 1'b0;
    case (state)
      S_FETCH: begin
        ctrl.addr_sel = A_PC;
        ctrl.rd       = 1'b1;
        ctrl.ir_en    = 1'b1;
        ctrl.x_sel    = X_PC;
        ctrl.alu_fs   = ALU_INC;
        ctrl.pc_en    = 1'b1;
      end
      S_EXEC: begin
        case (f)
          OP_LDA: begin
            ctrl.addr_sel = A_IR;
            ctrl.rd       = 1'b1;
            ctrl.y_sel    = Y_MEM;
            ctrl.alu_fs   = ALU_Y;
            ctrl.acc_en   = 1'b1;
          end
          OP_STA: begin
            ctrl.addr_sel = A_IR;
            ctrl.wr       = 1'b1;
          end
          OP_ADD, OP_SUB: begin
            ctrl.addr_sel = A_IR;
            ctrl.rd       = 1'b1;
            ctrl.x_sel    = X_ACC;
            ctrl.y_sel    = Y_MEM;
            ctrl.alu_fs   = (f == OP_SUB) ? ALU_SUB : ALU_ADD;
            ctrl.acc_en   = 1'b1;
          end
          // Conditional jumps collapse to an unconditional JMP when taken
          OP_JMP, OP_JGE, OP_JNE: begin
            if ((f == OP_JMP) || (f == OP_JGE && !n) || (f == OP_JNE && !z)) begin
              ctrl.y_sel  = Y_IMM;
              ctrl.alu_fs = ALU_Y;
              ctrl.pc_en  = 1'b1;
            end
          end
          OP_STP: halt_req = 1'b1;
          default: halt_req = (ILLEGAL_HALTS != 0);
        endcase
      end
      S_HALT: ctrl.halted = 1'b1;
      default: ctrl = '0;
    endcase
  end

endmodule

// File: rtl/mu0_control.sv
// MU0 control unit: fetch/execute/halt state machine driving the register bank.
// Optional instruction counter enabled by defining MU0_INSTR_COUNT_EN.
module mu0_control
  import mu0_pkg::*;
#(
  parameter int ILLEGAL_HALTS = 0
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic [3:0]  F,
  input  logic        N,
  input  logic        Z,
  output logic        PC_En,
  output logic        IR_En,
  output logic        ACC_En,
  output logic        X_sel,
  output logic        Y_sel,
  output logic        Addr_sel,
  output logic [1:0]  ALU_fs,
  output logic        Rd,
  output logic        Wr,
  output logic        Halted
`ifdef MU0_INSTR_COUNT_EN
  ,
  output logic [15:0] Instr_Count
`endif
);

  logic [1:0] state;
  logic [1:0] state_next;
  ctrl_t      dec_ctrl;
  ctrl_t      ctrl;
  logic       halt_req;

  mu0_decode #(
    .ILLEGAL_HALTS(ILLEGAL_HALTS)
  ) u_decode (
    .state    (state),
    .f        (F),
    .n        (N),
    .z        (Z),
    .ctrl     (dec_ctrl),
    .halt_req (halt_req)
  );

  // Reset overrides the decoded vector so no register can load mid-reset
  always_comb begin
    ctrl = Reset ? '0 : dec_ctrl;
  end

  always_comb begin
    state_next = S_FETCH;
    case (state)
      S_FETCH: state_next = S_EXEC;
      S_EXEC:  state_next = halt_req ? S_HALT : S_FETCH;
      S_HALT:  state_next = S_HALT;
      default: state_next = S_FETCH;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) state <= S_FETCH;
    else       state <= state_next;
  end

`ifdef MU0_INSTR_COUNT_EN
  logic [15:0] instr_count;

  // Every instruction retires on the edge leaving EXECUTE; HALT never increments
  always_ff @(posedge Clk) begin
    if (Reset)                 instr_count <= 16'h0000;
    else if (state == S_EXEC)  instr_count <= instr_count + 16'h0001;
  end

  assign Instr_Count = instr_count;
`endif

  assign PC_En    = ctrl.pc_en;
  assign IR_En    = ctrl.ir_en;
  assign ACC_En   = ctrl.acc_en;
  assign X_sel    = ctrl.x_sel;
  assign Y_sel    = ctrl.y_sel;
  assign Addr_sel = ctrl.addr_sel;
  assign ALU_fs   = ctrl.alu_fs;
  assign Rd       = ctrl.rd;
  assign Wr       = ctrl.wr;
  assign Halted   = ctrl.halted;

endmodule

// File: tb/tb_mu0_control.sv
// Directed testbench for mu0_control; expected control vectors are hand-written
// constants in {PC_En,IR_En,ACC_En,X_sel,Y_sel,Addr_sel,ALU_fs,Rd,Wr,Halted} order.
module tb_mu0_control;

  logic        Clk;
  logic        Reset;
  logic [3:0]  F;
  logic        N;
  logic        Z;
  logic        PC_En, IR_En, ACC_En, X_sel, Y_sel, Addr_sel, Rd, Wr, Halted;
  logic [1:0]  ALU_fs;
`ifdef MU0_INSTR_COUNT_EN
  logic [15:0] Instr_Count;
`endif

  int vectors = 0;
  int miscompares = 0;

  localparam logic [10:0] V_NONE  = 11'b0_0_0_0_0_0_00_0_0_0;
  localparam logic [10:0] V_FETCH = 11'b1_1_0_1_0_0_10_1_0_0;
  localparam logic [10:0] V_LDA   = 11'b0_0_1_0_0_1_00_1_0_0;
  localparam logic [10:0] V_STA   = 11'b0_0_0_0_0_1_00_0_1_0;
  localparam logic [10:0] V_ADD   = 11'b0_0_1_0_0_1_01_1_0_0;
  localparam logic [10:0] V_SUB   = 11'b0_0_1_0_0_1_11_1_0_0;
  localparam logic [10:0] V_JMP   = 11'b1_0_0_0_1_0_00_0_0_0;
  localparam logic [10:0] V_HALT  = 11'b0_0_0_0_0_0_00_0_0_1;

  mu0_control dut (
    .Clk         (Clk),
    .Reset       (Reset),
    .F           (F),
    .N           (N),
    .Z           (Z),
    .PC_En       (PC_En),
    .IR_En       (IR_En),
    .ACC_En      (ACC_En),
    .X_sel       (X_sel),
    .Y_sel       (Y_sel),
    .Addr_sel    (Addr_sel),
    .ALU_fs      (ALU_fs),
    .Rd          (Rd),
    .Wr          (Wr),
    .Halted      (Halted)
`ifdef MU0_INSTR_COUNT_EN
    ,
    .Instr_Count (Instr_Count)
`endif
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  function automatic logic [10:0] obs();
    return {PC_En, IR_En, ACC_En, X_sel, Y_sel, Addr_sel, ALU_fs, Rd, Wr, Halted};
  endfunction

  // Advance to 2 time units after the next rising edge
  task automatic next_cycle();
    @(posedge Clk);
    #2;
  endtask

  // Starting in a FETCH cycle, run one instruction; returns the FETCH and
  // EXECUTE observations and leaves the bench in the following cycle.
  task automatic run_instr(input logic [3:0] op, input logic n_in, input logic z_in,
                           output logic [10:0] fetch_obs, output logic [10:0] exec_obs);
    F = op; N = n_in; Z = z_in;
    #1;
    fetch_obs = obs();
    next_cycle();
    exec_obs = obs();
    next_cycle();
  endtask

  task automatic test_reset();
    Reset = 1'b1; F = 4'd7; N = 1'b0; Z = 1'b0;
    repeat (2) @(posedge Clk);
    #1;
    vectors++;
    if (obs() !== V_NONE) begin
      miscompares++;
      $display("[TB] FAIL reset_hold: got %b expected %b", obs(), V_NONE);
    end
    Reset = 1'b0;
    #1;
    vectors++;
    if (obs() !== V_FETCH) begin
      miscompares++;
      $display("[TB] FAIL reset_first_fetch: got %b expected %b", obs(), V_FETCH);
    end
  endtask

  task automatic test_lda();
    logic [10:0] fo, eo;
    run_instr(4'd0, 1'b0, 1'b0, fo, eo);
    vectors++;
    if (fo !== V_FETCH) begin
      miscompares++;
      $display("[TB] FAIL lda_fetch: got %b expected %b", fo, V_FETCH);
    end
    vectors++;
    if (eo !== V_LDA) begin
      miscompares++;
      $display("[TB] FAIL lda_exec: got %b expected %b", eo, V_LDA);
    end
    vectors++;
    if (obs() !== V_FETCH) begin
      miscompares++;
      $display("[TB] FAIL lda_next_fetch: got %b expected %b", obs(), V_FETCH);
    end
  endtask

  task automatic test_arith_store();
    logic [10:0] fo, eo;
    run_instr(4'd1, 1'b1, 1'b1, fo, eo);
    vectors++;
    if (eo !== V_STA) begin
      miscompares++;
      $display("[TB] FAIL sta_exec: got %b expected %b", eo, V_STA);
    end
    run_instr(4'd2, 1'b0, 1'b1, fo, eo);
    vectors++;
    if (eo !== V_ADD) begin
      miscompares++;
      $display("[TB] FAIL add_exec: got %b expected %b", eo, V_ADD);
    end
    run_instr(4'd3, 1'b1, 1'b0, fo, eo);
    vectors++;
    if (eo !== V_SUB) begin
      miscompares++;
      $display("[TB] FAIL sub_exec: got %b expected %b", eo, V_SUB);
    end
  endtask

  task automatic test_jumps();
    logic [10:0] fo, eo;
    run_instr(4'd4, 1'b1, 1'b1, fo, eo);
    vectors++;
    if (eo !== V_JMP) begin
      miscompares++;
      $display("[TB] FAIL jmp_exec: got %b expected %b", eo, V_JMP);
    end
    run_instr(4'd5, 1'b1, 1'b0, fo, eo);
    vectors++;
    if (eo !== V_NONE) begin
      miscompares++;
      $display("[TB] FAIL jge_not_taken: got %b expected %b", eo, V_NONE);
    end
    run_instr(4'd5, 1'b0, 1'b1, fo, eo);
    vectors++;
    if (eo !== V_JMP) begin
      miscompares++;
      $display("[TB] FAIL jge_taken: got %b expected %b", eo, V_JMP);
    end
    run_instr(4'd6, 1'b0, 1'b1, fo, eo);
    vectors++;
    if (eo !== V_NONE) begin
      miscompares++;
      $display("[TB] FAIL jne_not_taken: got %b expected %b", eo, V_NONE);
    end
    run_instr(4'd6, 1'b1, 1'b0, fo, eo);
    vectors++;
    if (eo !== V_JMP) begin
      miscompares++;
      $display("[TB] FAIL jne_taken: got %b expected %b", eo, V_JMP);
    end
  endtask

  task automatic test_illegal_nop();
    logic [10:0] fo, eo;
    run_instr(4'd9, 1'b0, 1'b0, fo, eo);
    vectors++;
    if (eo !== V_NONE) begin
      miscompares++;
      $display("[TB] FAIL nop_exec: got %b expected %b", eo, V_NONE);
    end
    run_instr(4'd15, 1'b1, 1'b1, fo, eo);
    vectors++;
    if (obs() !== V_FETCH) begin
      miscompares++;
      $display("[TB] FAIL nop_next_fetch: got %b expected %b", obs(), V_FETCH);
    end
  endtask

  task automatic test_halt();
    logic [10:0] fo, eo;
    run_instr(4'd7, 1'b0, 1'b0, fo, eo);
    vectors++;
    if (eo !== V_NONE) begin
      miscompares++;
      $display("[TB] FAIL stp_exec: got %b expected %b", eo, V_NONE);
    end
    for (int i = 0; i < 10; i++) begin
      F = 4'($urandom_range(0, 15));
      N = 1'($urandom_range(0, 1));
      Z = 1'($urandom_range(0, 1));
      #1;
      vectors++;
      if (obs() !== V_HALT) begin
        miscompares++;
        $display("[TB] FAIL halt_hold[%0d]: got %b expected %b", i, obs(), V_HALT);
      end
      next_cycle();
    end
    Reset = 1'b1;
    next_cycle();
    Reset = 1'b0;
    #1;
    vectors++;
    if (obs() !== V_FETCH) begin
      miscompares++;
      $display("[TB] FAIL halt_reset_fetch: got %b expected %b", obs(), V_FETCH);
    end
  endtask

  task automatic test_mid_reset();
    F = 4'd0;
    next_cycle();
    Reset = 1'b1;
    #1;
    vectors++;
    if (obs() !== V_NONE) begin
      miscompares++;
      $display("[TB] FAIL midreset_forced: got %b expected %b", obs(), V_NONE);
    end
    next_cycle();
    Reset = 1'b0;
    #1;
    vectors++;
    if (obs() !== V_FETCH) begin
      miscompares++;
      $display("[TB] FAIL midreset_fetch: got %b expected %b", obs(), V_FETCH);
    end
  endtask

`ifdef MU0_INSTR_COUNT_EN
  task automatic test_instr_count();
    logic [10:0] fo, eo;
    Reset = 1'b1;
    next_cycle();
    Reset = 1'b0;
    vectors++;
    if (Instr_Count !== 16'd0) begin
      miscompares++;
      $display("[TB] FAIL count_reset: got %h expected 0000", Instr_Count);
    end
    run_instr(4'd0, 1'b0, 1'b0, fo, eo);
    run_instr(4'd1, 1'b0, 1'b0, fo, eo);
    run_instr(4'd2, 1'b0, 1'b0, fo, eo);
    run_instr(4'd7, 1'b0, 1'b0, fo, eo);
    vectors++;
    if (Instr_Count !== 16'd4) begin
      miscompares++;
      $display("[TB] FAIL count_four: got %h expected 0004", Instr_Count);
    end
    repeat (3) next_cycle();
    vectors++;
    if (Instr_Count !== 16'd4) begin
      miscompares++;
      $display("[TB] FAIL count_held: got %h expected 0004", Instr_Count);
    end
    Reset = 1'b1;
    next_cycle();
    Reset = 1'b0;
    force dut.instr_count = 16'hFFFF;
    #1;
    release dut.instr_count;
    run_instr(4'd0, 1'b0, 1'b0, fo, eo);
    vectors++;
    if (Instr_Count !== 16'h0000) begin
      miscompares++;
      $display("[TB] FAIL count_wrap: got %h expected 0000", Instr_Count);
    end
  endtask
`endif

  initial begin
    Reset = 1'b1; F = 4'd0; N = 1'b0; Z = 1'b0;
    test_reset();
    test_lda();
    test_arith_store();
    test_jumps();
    test_illegal_nop();
    test_mid_reset();
    test_halt();
`ifdef MU0_INSTR_COUNT_EN
    test_instr_count();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
